// File: rtl/counter_timer_arbiter.sv
// counter_timer_arbiter
//
// Shares one external W-bit up-counter between N_REQ requesters as a timed
// interval resource. Requesters are served round-robin. For each grant the
// counter is cleared for one cycle and then enabled until it reaches the
// owner's requested length. After that the owner receives a one-cycle done pulse.
//
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous, active-high reset
//   req        - level request per requester, held until its done pulse
//   len        - per-requester interval length, requester i at [i*CNT_W +: CNT_W]
//   count      - current value of the shared counter
//   cnt_reset  - synchronous clear to the counter
//   cnt_enable - count enable to the counter
//   grant      - one-hot owner of the counter, zero when idle
//   cur_id     - index of the current owner, valid while busy
//   done       - one-cycle pulse to the owner at interval end
//   busy       - high whenever an interval is in progress

module counter_timer_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2,
    parameter int unsigned CNT_W = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] len,
    input  logic [CNT_W-1:0]       count,
    output logic                   cnt_reset,
    output logic                   cnt_enable,
    output logic [N_REQ-1:0]       grant,
    output logic [ID_W-1:0]        cur_id,
    output logic [N_REQ-1:0]       done,
    output logic                   busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  cur_id_q, cur_id_d;
    logic [ID_W-1:0]  rr_q, rr_d;
    logic [CNT_W-1:0] target_q, target_d;

    logic             found;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  sel;
    logic [N_REQ-1:0] owner_oh;

    // Round-robin pick: first asserted request at or after rr_q, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        sel    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            sel = ID_W'((32'(rr_q) + k) % N_REQ);
            if (!found && req[sel]) begin
                found  = 1'b1;
                winner = sel;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        rr_d     = rr_q;
        target_d = target_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    cur_id_d = winner;
                    target_d = len[winner*CNT_W +: CNT_W];
                    state_d  = CLEAR;
                end
            end
            CLEAR: begin
                state_d = (target_q == '0) ? DONE : RUN;
            end
            RUN: begin
                // The edge leaving RUN is the one that brings the counter to target.
                if (count == target_q - CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                rr_d    = (cur_id_q == ID_W'(N_REQ - 1)) ? '0 : cur_id_q + ID_W'(1);
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cur_id_q <= '0;
            rr_q     <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
            rr_q     <= rr_d;
            target_q <= target_d;
        end
    end

    // Outputs are decoded from registered state only.
    assign owner_oh   = N_REQ'(1) << cur_id_q;
    assign busy       = (state_q != IDLE);
    assign cnt_reset  = (state_q == CLEAR);
    assign cnt_enable = (state_q == RUN);
    assign grant      = busy ? owner_oh : '0;
    assign done       = (state_q == DONE) ? owner_oh : '0;
    assign cur_id     = cur_id_q;

endmodule

// File: tb/tb_counter_timer_arbiter.sv
// Testbench for counter_timer_arbiter: directed scenarios followed by a
// randomized phase, checked against a transaction-level model.

module tb_counter_timer_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int CW = 4;
    localparam int LW = N * CW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req   = '0;
    logic [LW-1:0] len   = '0;
    logic [CW-1:0] count;
    logic          cnt_reset;
    logic          cnt_enable;
    logic [N-1:0]  grant;
    logic [IW-1:0] cur_id;
    logic [N-1:0]  done;
    logic          busy;

    int vectors = 0;
    int errs    = 0;
    int rr_m    = 0;
    int id;

    counter_timer_arbiter #(
        .N_REQ (N),
        .ID_W  (IW),
        .CNT_W (CW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .len        (len),
        .count      (count),
        .cnt_reset  (cnt_reset),
        .cnt_enable (cnt_enable),
        .grant      (grant),
        .cur_id     (cur_id),
        .done       (done),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // The shared counter, on the same system reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) count <= '0;
        else if (cnt_reset) count <= '0;
        else if (cnt_enable) count <= count + CW'(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " grant"}, 32'(grant), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " cnt_reset"}, 32'(cnt_reset), 0);
        check({tag, " cnt_enable"}, 32'(cnt_enable), 0);
    endtask

    // Round-robin choice: first asserted request at or after pointer p.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Serve one interval from the IDLE cycle through the following IDLE cycle.
    // mode 0: plain; 1: owner drops req, changes len and raises the next
    // requester mid-RUN; 2: random req/len churn every RUN cycle.
    task automatic serve(input int mode, output int win);
        logic [N-1:0]  r;
        logic [LW-1:0] lv;
        logic [N-1:0]  oh;
        logic          entry_nz;
        int            n;
        int            tlen;
        r        = req;
        lv       = len;
        entry_nz = (req != '0);
        n        = 0;
        win      = -1;
        @(negedge clock);
        while (grant == '0 && n < 40) begin
            r  = req;
            lv = len;
            n++;
            @(negedge clock);
        end
        if (grant == '0) begin
            vectors++;
            errs++;
            $error("FAIL grant timeout: grant %b expected nonzero", grant);
            return;
        end
        if (entry_nz) check("idle gap", n, 0);
        win = pick(r, rr_m);
        if (win < 0) begin
            vectors++;
            errs++;
            $error("FAIL spurious grant: grant %b expected 0", grant);
            return;
        end
        tlen = int'(lv[win*CW +: CW]);
        oh   = N'(1) << win;
        check("clear grant", 32'(grant), 32'(oh));
        check("clear cur_id", 32'(cur_id), win);
        check("clear busy", 32'(busy), 1);
        check("clear cnt_reset", 32'(cnt_reset), 1);
        check("clear cnt_enable", 32'(cnt_enable), 0);
        check("clear done", 32'(done), 0);
        for (int c = 0; c < tlen; c++) begin
            @(negedge clock);
            check("run grant", 32'(grant), 32'(oh));
            check("run cnt_enable", 32'(cnt_enable), 1);
            check("run cnt_reset", 32'(cnt_reset), 0);
            check("run done", 32'(done), 0);
            check("run count", 32'(count), c);
            if (mode == 1 && c == 1) begin
                req[win]              = 1'b0;
                req[(win + 1) % N]    = 1'b1;
                len[win*CW +: CW]     = CW'(3);
            end else if (mode == 2) begin
                req = N'($urandom);
                len = LW'($urandom);
            end
        end
        @(negedge clock);
        check("done pulse", 32'(done), 32'(oh));
        check("done grant", 32'(grant), 32'(oh));
        check("done count", 32'(count), tlen);
        check("done cnt_enable", 32'(cnt_enable), 0);
        check("done busy", 32'(busy), 1);
        @(negedge clock);
        check_idle("post");
        check("post count", 32'(count), tlen);
        rr_m = (win + 1) % N;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge clock);
        @(negedge clock);
        check_idle("reset");
        check("reset cur_id", 32'(cur_id), 0);
        check("reset count", 32'(count), 0);
        reset = 1'b0;
        rr_m  = 0;
        @(negedge clock);
        check_idle("idle no req");

        // Single requester, len 5
        req = 4'b0010;
        len[1*CW +: CW] = 4'd5;
        serve(0, id);
        req = '0;
        check("t1 id", id, 1);

        // Zero-length interval
        req = 4'b0100;
        len[2*CW +: CW] = 4'd0;
        serve(0, id);
        req = '0;
        check("t2 id", id, 2);

        // Maximum length
        req = 4'b0001;
        len[0*CW +: CW] = 4'd15;
        serve(0, id);
        req = '0;
        check("t4 id", id, 0);

        // Owner drops req and changes len mid-RUN; req[1] becomes pending
        len = {4'd4, 4'd4, 4'd3, 4'd6};
        req = 4'b0001;
        serve(1, id);
        check("t6 id", id, 0);
        serve(0, id);
        req = '0;
        check("t6 next id", id, 1);

        // Fairness from reset with all requests held
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        rr_m  = 0;
        len   = {4'd2, 4'd2, 4'd2, 4'd2};
        req   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            serve(0, id);
            check("rr order", id, k % N);
        end
        req = '0;
        @(negedge clock);

        // Reset in the middle of RUN
        req = 4'b1000;
        len[3*CW +: CW] = 4'd8;
        for (int n = 0; n < 40 && grant == '0; n++) @(negedge clock);
        check("t5 grant", 32'(grant), 32'b1000);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check("t5 run enable", 32'(cnt_enable), 1);
        end
        reset = 1'b1;
        #1;
        check_idle("async reset");
        check("async reset cur_id", 32'(cur_id), 0);
        check("async reset count", 32'(count), 0);
        @(negedge clock);
        check_idle("held reset");
        reset = 1'b0;
        rr_m  = 0;
        serve(0, id);
        req = '0;
        check("t5 restart id", id, 3);

        // Randomized phase
        for (int t = 0; t < 30; t++) begin
            req = N'($urandom_range(1, (1 << N) - 1));
            len = LW'($urandom);
            serve(2, id);
        end
        req = '0;
        @(negedge clock);
        check_idle("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/counter_timer_arbiter.md
Name: counter_timer_arbiter

Overview:
Shares one W-bit up-counter between N requesters as a timed-interval resource.
Each requester asks for an interval of LEN clock ticks. The arbiter grants requesters in round-robin order, clears the counter, enables it, and watches its count. When the interval ends it pulses done to the owner.
It drives the counter's reset/enable pins and observes its count output. The counter clears synchronously on its reset pin and increments on each clock edge while enabled.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester index; must satisfy 2**ID_W >= N_REQ
CNT_W, 4, counter width and per-requester length width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  N_REQ  level request per requester; held until its done pulse
len  input  N_REQ*CNT_W  interval length; requester i uses bits [i*CNT_W +: CNT_W]
count  input  CNT_W  current value from the shared counter
cnt_reset  output  1  synchronous clear to the counter
cnt_enable  output  1  count enable to the counter
grant  output  N_REQ  one-hot owner of the counter; zero when idle
cur_id  output  ID_W  index of the current owner; valid while busy
done  output  N_REQ  one-cycle pulse to the owner at interval end
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async): state=IDLE, grant=0, done=0, cnt_reset=0, cnt_enable=0, busy=0, cur_id=0, rr pointer=0, target=0.
- Timing: all outputs registered or decoded from registered state only. No combinational path from req/len/count to outputs.
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - If req != 0, select the first asserted req at or after the rr pointer, wrapping modulo N_REQ.
  - Latch the winner's index into cur_id and its len into target. Set grant one-hot. Go to CLEAR.
  - If req == 0, stay in IDLE.
- CLEAR: cnt_reset=1 for exactly one cycle; cnt_enable=0.
  - target==0 -> DONE.
  - Otherwise -> RUN.
- RUN: cnt_enable=1 every cycle. When count == target-1, go to DONE; on that edge the counter reaches target.
  - RUN lasts exactly target cycles.
- DONE: cnt_enable=0, so the counter holds target. done[cur_id]=1 for this single cycle; grant stays asserted this cycle.
  - Next: grant=0, rr pointer=cur_id+1 mod N_REQ, state=IDLE.
- Latency: done rises exactly target+1 cycles after grant rises; grant stays high target+2 cycles.
  - Back-to-back grants are separated by exactly one IDLE cycle.
- Width: len=2**CNT_W-1 (15 at default) is the maximum interval. Counter never wraps during RUN.
- req dropped while owned: ignored. The interval completes and done still pulses.
  - len changes after sampling are ignored.
- New requests while busy wait. They are arbitrated only in IDLE.
- Fairness: with all req held continuously, grants cycle 0,1,...,N_REQ-1,0,...
- Reset mid-operation (any state): immediate return to reset values.
  - No done pulse for the aborted interval.
  - The counter is on the same system reset.

Test Plan:
- req[1]=1, len1=5, others idle -> grant=0010 and cur_id=1 for 7 cycles. cnt_reset high 1 cycle. cnt_enable high 5 cycles. done[1] pulses 6 cycles after grant rises with count=5. busy falls after.
- req[2]=1, len2=0 -> CLEAR then DONE. done[2] one cycle after grant rises. cnt_enable never asserted. count=0.
- req=1111 held, all len=2, from reset -> grant order 0,1,2,3,0. Each grant 4 cycles, one IDLE cycle between. Exactly one done per grant.
- req[0]=1, len0=15 -> cnt_enable high 15 cycles. done[0] with count=15. No counter wrap.
- req[3]=1, len3=8; assert reset after 4 RUN cycles -> all outputs 0 immediately, no done. After release with req[3] still high, a fresh 8-tick interval completes normally.
- req[0] granted; req[0] deasserted and len0 changed mid-RUN -> interval still completes with the original length and done[0] pulses. A pending req[1] is granted one cycle later.
